// File: rtl/nibble_add_pkg.sv
// Shared constants, FSM state encoding and index-width helper for the nibble-serial adder.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index register width: clog2(n), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Plain combinational 4-bit adder with carry in and carry out.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that time-shares one adder_4bit, one nibble per clock, LSB first.
// Optional overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // Handshake: start is taken on a rising edge only while state is IDLE or DONE
  // (a/b/cin captured on that same edge); busy is high for the NIBBLES RUN cycles;
  // done pulses for exactly one cycle with sum/cout valid, and they hold until the
  // next DONE. There is no backpressure and start during RUN is dropped.
  state_e state, next_state;

  logic [WIDTH-1:0] a_q, b_q, sum_acc, acc_next;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  adder_4bit u_adder (
    .a    (a_q[NIBBLE_W*idx +: NIBBLE_W]),
    .b    (b_q[NIBBLE_W*idx +: NIBBLE_W]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign last = (idx == IDX_W'(NIBBLES - 1));

  // Accumulator with the current nibble merged in, so the final nibble can be
  // published to sum on the same edge it is produced.
  always_comb begin
    acc_next = sum_acc;
    acc_next[NIBBLE_W*idx +: NIBBLE_W] = nib_sum;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_acc <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_acc <= acc_next;
          carry_q <= nib_cout;
          idx     <= idx + 1'b1;
          if (last) begin
            sum_q  <= acc_next;
            cout_q <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && last) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table, scoreboard queue,
// hand-written sequences for mid-RUN start, back-to-back start and mid-RUN reset.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {v, s};
  endfunction

  // Drive a start request at the current negedge; optionally record the expectation.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit push);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    if (push) exp_q.push_back(model(x, y, c));
  endtask

  // Wait for done after a start driven at the current negedge. At negedge number
  // 'poke' a fresh start with a=1 is injected, which must be ignored.
  task automatic wait_result(input int poke);
    int lat;
    int busy_cnt;
    logic [W+1:0] e;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (lat == poke) begin
        start = 1'b1;
        a = 16'h0001;
        b = W'($urandom);
      end else begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", lat, NIB + 1);
    check("busy_cycles", busy_cnt, NIB);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sum", {16'd0, sum}, {16'd0, e[W-1:0]});
      check("cout", {31'd0, cout}, {31'd0, e[W]});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check("ovf", {31'd0, ovf}, {31'd0, e[W+1]});
`endif
    end
  endtask

  // One cycle after done: pulse gone, back in IDLE, result held.
  task automatic check_hold(input logic [W-1:0] s, input logic c);
    @(negedge clk);
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("sum_hold", {16'd0, sum}, {16'd0, s});
    check("cout_hold", {31'd0, cout}, {31'd0, c});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W+1:0] m;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1};
    vecs[5] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    vecs[6] = '{16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_sum", {16'd0, sum}, 32'd0);
    end

    // table vectors; expected comes from the table, model only supplies ovf
    for (int i = 0; i < 8; i++) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin);
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      exp_q.push_back({m[W+1], vecs[i].exp_cout, vecs[i].exp_sum});
      wait_result(0);
      check_hold(vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // start during RUN ignored, then back-to-back start held in DONE
    @(negedge clk);
    start_op(16'h1234, 16'h4321, 1'b0, 1'b1);
    wait_result(2);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_result(0);
    check_hold(16'h0002, 1'b0);

    // reset in the second RUN cycle discards the operation
    @(negedge clk);
    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("run1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
    end
    start_op(16'h000F, 16'h0001, 1'b0, 1'b1);
    wait_result(0);

    // random operations, some back-to-back
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, 32'hFFFF));
      rb = W'($urandom_range(0, 32'hFFFF));
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      start_op(ra, rb, rc, 1'b1);
      wait_result(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NIB)) : 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle adder for WIDTH-bit operands built around one adder_4bit instance, which it time-shares. It processes one 4-bit nibble per clock, LSB first, and ripples the carry through a register between nibbles. It sits directly upstream of adder_4bit, sequencing operand nibbles into it and collecting its sum/cout. It gives the datapath wide additions at 4-bit adder area cost, behind a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIBBLES, WIDTH/4, derived: number of RUN cycles per operation; not user-overridable.

Ports:
- clk  input  1  single clock; everything updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new addition; acted on only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepted start edge only.
- b  input  WIDTH  operand B; sampled on the accepted start edge only.
- cin  input  1  carry-in to nibble 0; sampled with a/b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; registered; held stable from done until the next accepted start.
- cout  output  1  carry-out of the top nibble; same timing as sum.

Behaviour:
- Reset (rst=1 on a clk edge):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand registers, carry register and nibble index clear to 0.
  - Reset overrides start and any in-flight operation, including mid-RUN; the partial result is discarded.
- States are IDLE, RUN and DONE.
  - IDLE: start=1 latches a, b, cin and sets idx=0, then goes to RUN. Otherwise stays in IDLE.
  - RUN: each cycle drives adder_4bit with a_q[4*idx+:4], b_q[4*idx+:4] and the carry register.
    - The 4-bit sum is written into sum_acc[4*idx+:4]; the adder cout goes into the carry register; idx increments.
    - When idx==NIBBLES-1, go to DONE instead.
    - start is ignored in RUN; no queueing.
  - DONE: lasts exactly one cycle.
    - done=1, busy=0; sum and cout show the final result.
    - start=1 in DONE is accepted (back-to-back): new operands are latched and the next state is RUN.
    - Otherwise the next state is IDLE.
- Latency:
  - Start accepted at edge T gives RUN during cycles T+1..T+NIBBLES.
  - done is high in cycle T+NIBBLES+1.
  - Throughput is one result every NIBBLES+1 cycles.
- Output update rules:
  - sum/cout are updated only on entry to DONE; they do not show intermediate nibbles.
  - They hold their value through IDLE until the next DONE.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no saturation.
- Operand inputs may change freely after the accepted start edge without affecting the result.
- WIDTH=4 (NIBBLES=1): exactly one RUN cycle; all rules above still apply.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit: two's-complement overflow, defined as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - ovf uses the same update and hold timing as sum/cout; its reset value is 0.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package nibble_add_pkg:
  - constant NIBBLE_W=4.
  - state enum {IDLE, RUN, DONE} as a 2-bit encoding.
  - helper function computing the index width, clog2(NIBBLES) with a minimum of 1.
- Sub-module: the existing adder_4bit, instantiated once, unmodified.
- Everything else (FSM, operand/carry/index registers, accumulator) lives inside nibble_serial_adder.

Test Plan:
- Reset then idle (WIDTH=16): after rst, busy=0, done=0, sum=0, cout=0; with no start for 10 cycles they stay at 0.
- a=16'h1234, b=16'h4321, cin=0, start pulse -> busy high for 4 cycles; done in cycle T+5 with sum=16'h5555, cout=0.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1; also a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Start during RUN and operand change: start asserted again mid-RUN with a=16'h0001 while a/b change -> ignored; the first result is unchanged. Then start held high in DONE with a=16'h0001, b=16'h0001 -> back-to-back RUN and the next done gives sum=16'h0002.
- Reset mid-operation: rst in the 2nd RUN cycle of 16'hAAAA+16'h5555 -> next cycle IDLE with all outputs 0; a fresh start with 16'h000F+16'h0001 gives sum=16'h0010.
- With NIBBLE_SERIAL_ADDER_OVF_EN: 16'h7FFF+16'h0001 gives ovf=1, sum=16'h8000; 16'h8000+16'hFFFF gives ovf=1, sum=16'h7FFF, cout=1; 16'h1234+16'h4321 gives ovf=0.
